// File: rtl/round_arb.sv
// Two-requester arbiter sharing one exponent-adjust stage (overflow saturation to max finite).
// Define ROUND_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module round_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ovf_en,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [10:0] req0_e2,
  input  logic        req0_db,
  input  logic        req0_sigovf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [10:0] req1_e2,
  input  logic        req1_db,
  input  logic        req1_sigovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_e3,
  output logic        res_ovf,
  output logic        res_src
);

  typedef enum logic [1:0] {StIdle, StAdj, StHold} state_e;

  state_e      state_q, state_d;
  logic        any_req;
  logic        grant;
  logic        gnt_src;

  logic [10:0] e2_q;
  logic        db_q;
  logic        sigovf_q;
  logic        ovf_en_q;
  logic        src_q;

  logic        all_ones;
  logic        ovf;
  logic [10:0] e3_adj;

  logic        res_valid_q;
  logic [10:0] res_e3_q;
  logic        res_ovf_q;
  logic        res_src_q;

  assign any_req = req0_valid | req1_valid;
  // Gating with rst_n keeps ready low while reset is held, even with state at StIdle.
  assign grant   = (state_q == StIdle) & any_req & rst_n;

`ifdef ROUND_ARB_RR_EN
  logic prio_q;  // requester that wins the next simultaneous request

  always_comb begin
    gnt_src = ~req0_valid;
    if (req0_valid && req1_valid) gnt_src = prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (grant) begin
      prio_q <= ~gnt_src;
    end
  end
`else
  assign gnt_src = ~req0_valid;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StAdj;
      StAdj:   state_d = StHold;
      StHold:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = grant & ~gnt_src;
    req1_ready = grant & gnt_src;
  end

  always_comb begin
    all_ones = db_q ? (&e2_q) : (&e2_q[7:0]);
    ovf      = sigovf_q & all_ones;
    e3_adj   = e2_q;
    if (ovf && !ovf_en_q) e3_adj = db_q ? 11'h7FE : 11'h0FE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e2_q     <= '0;
      db_q     <= 1'b0;
      sigovf_q <= 1'b0;
      ovf_en_q <= 1'b0;
      src_q    <= 1'b0;
    end else if (grant) begin
      e2_q     <= gnt_src ? req1_e2 : req0_e2;
      db_q     <= gnt_src ? req1_db : req0_db;
      sigovf_q <= gnt_src ? req1_sigovf : req0_sigovf;
      ovf_en_q <= ovf_en;
      src_q    <= gnt_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_e3_q    <= '0;
      res_ovf_q   <= 1'b0;
      res_src_q   <= 1'b0;
    end else if (state_q == StAdj) begin
      res_valid_q <= 1'b1;
      res_e3_q    <= e3_adj;
      res_ovf_q   <= ovf;
      res_src_q   <= src_q;
    end else if (state_q == StHold && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_e3    = res_e3_q;
  assign res_ovf   = res_ovf_q;
  assign res_src   = res_src_q;

endmodule

// File: tb/tb_round_arb.sv
// Directed self-checking bench for round_arb; expectations computed by hand.
module tb_round_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ovf_en = 1'b0;
  logic        req0_valid = 1'b0, req0_db = 1'b0, req0_sigovf = 1'b0;
  logic        req1_valid = 1'b0, req1_db = 1'b0, req1_sigovf = 1'b0;
  logic [10:0] req0_e2 = '0, req1_e2 = '0;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_ready = 1'b1;
  logic [10:0] res_e3;
  logic        res_ovf, res_src;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  round_arb u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ovf_en     (ovf_en),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_e2    (req0_e2),
    .req0_db    (req0_db),
    .req0_sigovf(req0_sigovf),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_e2    (req1_e2),
    .req1_db    (req1_db),
    .req1_sigovf(req1_sigovf),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_e3     (res_e3),
    .res_ovf    (res_ovf),
    .res_src    (res_src)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic [10:0] e2, input logic db, input logic sig);
    if (r == 0) begin
      req0_valid = 1'b1; req0_e2 = e2; req0_db = db; req0_sigovf = sig;
    end else begin
      req1_valid = 1'b1; req1_e2 = e2; req1_db = db; req1_sigovf = sig;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_e2 = '0; req0_db = 1'b0; req0_sigovf = 1'b0;
    req1_valid = 1'b0; req1_e2 = '0; req1_db = 1'b0; req1_sigovf = 1'b0;
  endtask

  // Grant in cycle 0, idle ADJ in cycle 1, result in cycle 2; ovf_en flipped after grant.
  task automatic run_txn(input string tag, input int r, input logic [10:0] e2, input logic db,
                         input logic sig, input logic en, input logic [10:0] exp_e3,
                         input logic exp_ovf);
    @(negedge clk);
    res_ready = 1'b1;
    ovf_en = en;
    drive(r, e2, db, sig);
    #1;
    check_eq({tag, ".ready"}, (r == 0) ? req0_ready : req1_ready, 1);
    check_eq({tag, ".other_ready"}, (r == 0) ? req1_ready : req0_ready, 0);
    @(negedge clk);
    clear_reqs();
    ovf_en = ~en;
    #1;
    check_eq({tag, ".valid_adj"}, res_valid, 0);
    @(negedge clk);
    check_eq({tag, ".valid"}, res_valid, 1);
    check_eq({tag, ".e3"}, res_e3, exp_e3);
    check_eq({tag, ".ovf"}, res_ovf, exp_ovf);
    check_eq({tag, ".src"}, res_src, r[0]);
  endtask

  initial begin
    int last_t;
    int ngnt;
    logic [3:0] exp_seq;

    // Reset state, with a request pending during reset
    req0_valid = 1'b1;
    #2;
    check_eq("rst.valid", res_valid, 0);
    check_eq("rst.e3", res_e3, 0);
    check_eq("rst.ovf", res_ovf, 0);
    check_eq("rst.src", res_src, 0);
    check_eq("rst.ready0", req0_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.ready0_held", req0_ready, 0);
    clear_reqs();
    rst_n = 1'b1;

    run_txn("sat_dbl", 0, 11'h7FF, 1'b1, 1'b1, 1'b0, 11'h7FE, 1'b1);
    run_txn("trap_sgl", 1, 11'h3FF, 1'b0, 1'b1, 1'b1, 11'h3FF, 1'b1);
    run_txn("no_ones", 0, 11'h0FE, 1'b0, 1'b1, 1'b0, 11'h0FE, 1'b0);
    run_txn("sat_sgl", 1, 11'h3FF, 1'b0, 1'b1, 1'b0, 11'h0FE, 1'b1);
    run_txn("dbl_hi0", 0, 11'h0FF, 1'b1, 1'b1, 1'b0, 11'h0FF, 1'b0);
    run_txn("nosig", 1, 11'h7FF, 1'b1, 1'b0, 1'b0, 11'h7FF, 1'b0);

    // Back-pressure in HOLD with another requester waiting
    @(negedge clk);
    res_ready = 1'b0;
    drive(1, 11'h123, 1'b1, 1'b0);
    @(negedge clk);
    clear_reqs();
    drive(0, 11'h055, 1'b1, 1'b0);
    #1;
    check_eq("bp.ready0_adj", req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp.valid", res_valid, 1);
      check_eq("bp.e3", res_e3, 11'h123);
      check_eq("bp.src", res_src, 1);
      check_eq("bp.ready0", req0_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp.idle_ready0", req0_ready, 1);
    check_eq("bp.valid_done", res_valid, 0);
    clear_reqs();

    // Reset during ADJ drops the in-flight result
    @(negedge clk);
    drive(0, 11'h7FF, 1'b1, 1'b1);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b0;
    #1;
    check_eq("radj.valid", res_valid, 0);
    check_eq("radj.e3", res_e3, 0);
    check_eq("radj.src", res_src, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("radj.no_valid", res_valid, 0);
    end

    // Both requesting continuously for 4 grants
`ifdef ROUND_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    drive(0, 11'h011, 1'b1, 1'b0);
    drive(1, 11'h022, 1'b1, 1'b0);
    ngnt = 0;
    last_t = -1;
    for (int cyc = 0; cyc < 20 && ngnt < 4; cyc++) begin
      @(negedge clk);
      check_eq("arb.dual_ready", {31'd0, req0_ready & req1_ready}, 0);
      if (res_valid) begin
        check_eq("arb.src", res_src, exp_seq[ngnt]);
        if (last_t >= 0) check_eq("arb.spacing", cyc - last_t, 3);
        last_t = cyc;
        ngnt++;
      end
    end
    check_eq("arb.grants", ngnt, 4);
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/round_arb.md
ROUND_ARB -- requirements
Module: round_arb

Interface
REQ-001 The module SHALL expose: clk  in  1  rising-edge clock.
REQ-002 The module SHALL expose: rst_n  in  1  asynchronous active-low reset.
REQ-003 The module SHALL expose: ovf_en  in  1  overflow trap enable, sampled at grant.
REQ-004 The module SHALL expose, per requester i in {0=add, 1=mul}: reqi_valid in 1, reqi_ready out 1, reqi_e2 in 11 (exponent), reqi_db in 1 (1=double, 0=single), reqi_sigovf in 1 (significand overflow after rounding).
REQ-005 The module SHALL expose: res_valid out 1, res_ready in 1, res_e3 out 11, res_ovf out 1, res_src out 1 (granted requester id).

Function
REQ-006 The module SHALL share one exponent-adjust datapath between two requesters, with a valid/ready handshake on each side.
REQ-007 The module SHALL implement the FSM states IDLE, ADJ and HOLD.
REQ-008 IDLE: if any reqi_valid is high, the module SHALL grant one requester, assert reqi_ready for that requester for that cycle only, capture e2/db/sigovf/ovf_en, and go to ADJ.
REQ-009 ADJ, one cycle: the module SHALL compute the result into the output registers and go to HOLD with res_valid=1.
REQ-010 HOLD: res_valid SHALL stay 1 and res_e3/res_ovf/res_src SHALL stay stable until res_ready=1; on res_valid&res_ready the module SHALL go to IDLE.
REQ-011 The grant-to-res_valid latency SHALL be 2 cycles; the minimum spacing between consecutive grants SHALL be 3 cycles.
REQ-012 All-ones test: for db=1, the module SHALL evaluate &e2[10:0]; for db=0, &e2[7:0] (bits 10:8 ignored).
REQ-013 res_ovf SHALL equal sigovf & all-ones.
REQ-014 If res_ovf=1 and captured ovf_en=0, res_e3 SHALL saturate to the largest finite exponent: 11'h7FE for db=1, 11'h0FE for db=0.
REQ-015 In all other cases res_e3 SHALL equal the captured e2 unchanged, including when res_ovf=1 and ovf_en=1.
REQ-016 reqi_ready SHALL never be high outside IDLE, and never for both requesters in the same cycle.
REQ-017 A requester that holds valid without being granted SHALL keep its request pending; inputs are captured only in the grant cycle.
REQ-018 A change of ovf_en after the grant SHALL NOT affect the in-flight result.
REQ-019 When res_ready=1 in the same cycle res_valid first rises, the transaction SHALL complete in that cycle and the FSM SHALL be in IDLE the next cycle.

Reset
REQ-020 On rst_n=0 the module SHALL, asynchronously, force the FSM to IDLE, res_valid=0, res_e3=0, res_ovf=0, res_src=0, both reqi_ready=0, and the round-robin pointer to requester 0.
REQ-021 A reset asserted in ADJ or HOLD SHALL drop the in-flight result without emitting it.
REQ-022 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-023 With macro ROUND_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted most recently; the pointer updates only on a grant.
REQ-024 With ROUND_ARB_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 (add) always winning; the pointer logic SHALL be absent.

Verification
REQ-025 The bench SHALL cover: req0 db=1 e2=11'h7FF sigovf=1 ovf_en=0, res_ready=1 -> 2 cycles after grant res_valid=1, res_e3=11'h7FE, res_ovf=1, res_src=0.
REQ-026 The bench SHALL cover: req1 db=0 e2=11'h3FF sigovf=1 ovf_en=1 -> res_e3=11'h3FF, res_ovf=1, res_src=1.
REQ-027 The bench SHALL cover: req0 db=0 e2=11'h0FE sigovf=1 -> res_ovf=0, res_e3=11'h0FE.
REQ-028 The bench SHALL cover: both requesters valid continuously for 4 grants -> with ROUND_ARB_RR_EN res_src sequence 0,1,0,1; without it 0,0,0,0.
REQ-029 The bench SHALL cover: res_ready held 0 for 5 cycles in HOLD -> outputs stable, no reqi_ready pulses; then res_ready=1 -> IDLE next cycle.
REQ-030 The bench SHALL cover: rst_n pulled low during ADJ -> outputs zero immediately, and no res_valid appears for that transaction.
